if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage; producer of the {instr, pc} pair the decode stage consumes.
//  Holds the PC, issues one-outstanding requests to instruction memory, and buffers
//  returned words in a small FIFO. Presents them to ID with a valid/ready handshake.
//  Handles redirect (branch/jump) with flush and discard of the in-flight response.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC fetched first after reset
//  FIFO_DEPTH  2              fetch-buffer entries (power of 2, >= 2)
// PORTS
//  clk_i           in   1                 clock, all state on rising edge
//  rst_i           in   1                 synchronous, active-high reset
//  imem_req_o      out  1                 fetch request valid
//  imem_addr_o     out  `SYS_ADDR_SPACE   fetch address (word aligned)
//  imem_gnt_i      in   1                 request accepted this cycle
//  imem_rvalid_i   in   1                 response data valid
//  imem_rdata_i    in   `INST_WIDTH       response instruction word
//  redirect_i      in   1                 PC redirect from EXE, one-cycle pulse
//  redirect_pc_i   in   `SYS_ADDR_SPACE   redirect target
//  instr_o         out  `INST_WIDTH       instruction to ID
//  pc_o            out  `SYS_ADDR_SPACE   PC of instr_o
//  valid_o         out  1                 instr_o/pc_o valid
//  ready_i         in   1                 ID accepts this cycle
//  misalign_o      out  1                 only with IF_MISALIGN_TRAP_EN
// BEHAVIOUR
//  Reset: pc_q=RESET_PC, state=IDLE, FIFO empty, valid_o=0, imem_req_o=0,
//   imem_addr_o=RESET_PC, instr_o=32'h0000_0013 (NOP), pc_o=0, misalign_o=0.
//  FSM: IDLE -> REQ unconditionally one cycle after reset release.
//   REQ : imem_req_o=1, imem_addr_o=pc_q; gnt_i -> WAIT; req held stable until gnt.
//   WAIT: on rvalid_i push {pc_q, rdata_i}, pc_q+=4; -> REQ if credit else HOLD.
//   HOLD: -> REQ once credit available.
//   DRAIN: in-flight response owed to stale PC; next rvalid_i dropped -> REQ.
//  Credit: request issued only if fifo_count + outstanding < FIFO_DEPTH; FIFO never
//   overflows; push and pop in the same cycle always allowed.
//  Output: valid_o = FIFO non-empty; pop on valid_o & ready_i; head entry and
//   valid_o stable while ready_i=0. instr_o = NOP, pc_o = 0 when empty.
//  Latency: gnt at cycle N, rvalid at N+k -> valid_o at N+k+1 (registered FIFO).
//  Redirect (highest priority, over push/pop/stall): FIFO flushed, valid_o=0 next
//   cycle; pc_q<=redirect_pc_i. From IDLE/REQ(no gnt)/HOLD -> REQ. From WAIT without
//   rvalid, or REQ with gnt same cycle -> DRAIN. From WAIT with rvalid same cycle:
//   response dropped, -> REQ. Redirect in DRAIN: stays DRAIN, pc_q updated.
//  Redirect -> imem_req_o with new address: next cycle (unless DRAIN).
//  pc_q wraps modulo 2^`SYS_ADDR_SPACE; no flag.
//  Reset mid-transaction: all state cleared; late rvalid after reset ignored (IDLE).
// CONFIGURATION
//  IF_MISALIGN_TRAP_EN defined: redirect_pc_i[1:0]!=0 -> state TRAP, no requests,
//   misalign_o=1 until next aligned redirect or reset; FIFO flushed.
//  Undefined: redirect_pc_i[1:0] forced to 2'b00; misalign_o port absent; no TRAP.
// STRUCTURE
//  Shared defines header: `INST_WIDTH, `SYS_ADDR_SPACE, `NOP_INSTR (32'h13), FSM
//   state encodings IF_IDLE/IF_REQ/IF_WAIT/IF_HOLD/IF_DRAIN/IF_TRAP.
//  Sub-module fetch_fifo: synchronous FIFO of {pc, instr}, FIFO_DEPTH entries, flush
//   input, count output; top keeps FSM, PC and credit logic.
// TESTING
//  Reset, gnt=1, rvalid 1 cycle later, ready=1 -> pc_o 0x0,0x4,0x8 in order, no gaps
//   beyond memory latency; instr_o matches memory.
//  ready_i=0 for 10 cycles -> at most FIFO_DEPTH words buffered, imem_req_o drops,
//   head unchanged; ready_i=1 -> drains in order, no loss/duplication.
//  Redirect to 0x100 while in WAIT, rvalid 2 cycles later with stale word -> stale
//   word never on valid_o; next fetch addr 0x100.
//  Redirect to 0x200 same cycle as rvalid -> word dropped, imem_addr_o=0x200 next cycle.
//  gnt_i low 5 cycles -> imem_req_o/imem_addr_o stable throughout.
//  IF_MISALIGN_TRAP_EN: redirect to 0x102 -> misalign_o=1, no requests; redirect
//   0x104 -> misalign_o=0, fetch 0x104. Without macro: 0x102 fetches 0x100.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Widths, NOP encoding, FSM state encodings and the fetch-buffer entry layout.
package if_fetch_pkg;

    localparam int INST_WIDTH     = 32;
    localparam int SYS_ADDR_SPACE = 32;

    localparam logic [INST_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [2:0] IF_IDLE  = 3'd0;
    localparam logic [2:0] IF_REQ   = 3'd1;
    localparam logic [2:0] IF_WAIT  = 3'd2;
    localparam logic [2:0] IF_HOLD  = 3'd3;
    localparam logic [2:0] IF_DRAIN = 3'd4;
    localparam logic [2:0] IF_TRAP  = 3'd5;

    typedef struct packed {
        logic [SYS_ADDR_SPACE-1:0] pc;
        logic [INST_WIDTH-1:0]     instr;
    } fetch_entry_t;

    function automatic logic [SYS_ADDR_SPACE-1:0] word_align(input logic [SYS_ADDR_SPACE-1:0] addr);
        return addr & ~SYS_ADDR_SPACE'(3);
    endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// fetch_fifo: synchronous FIFO of {pc, instr} entries with flush and occupancy count.
// Head entry is presented combinationally from the storage array.
module fetch_fifo
    import if_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output logic         empty,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign head  = mem[rd_ptr_reg];

    // Flush wins over everything; a push into a full FIFO is only taken alongside a pop.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && ((count_reg != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage with PC, one-outstanding imem requests and a fetch buffer.
// Optional IF_MISALIGN_TRAP_EN adds misalign_o and a TRAP state for misaligned redirects.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [SYS_ADDR_SPACE-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                        FIFO_DEPTH = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    output logic                      imem_req_o,
    output logic [SYS_ADDR_SPACE-1:0] imem_addr_o,
    input  logic                      imem_gnt_i,
    input  logic                      imem_rvalid_i,
    input  logic [INST_WIDTH-1:0]     imem_rdata_i,
    input  logic                      redirect_i,
    input  logic [SYS_ADDR_SPACE-1:0] redirect_pc_i,
    output logic [INST_WIDTH-1:0]     instr_o,
    output logic [SYS_ADDR_SPACE-1:0] pc_o,
    output logic                      valid_o,
    input  logic                      ready_i
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic                      misalign_o
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [2:0]                state_reg;
    logic [2:0]                state_next;
    logic [SYS_ADDR_SPACE-1:0] pc_reg;
    logic [SYS_ADDR_SPACE-1:0] pc_next;
    logic [SYS_ADDR_SPACE-1:0] redirect_target;
    logic                      redirect_bad;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_flush;
    logic                      fifo_empty;
    logic [CW-1:0]             fifo_count;
    fetch_entry_t              fifo_head;
    fetch_entry_t              fifo_wdata;
    logic                      has_credit;
    logic                      granted;

`ifdef IF_MISALIGN_TRAP_EN
    assign redirect_target = redirect_pc_i;
    assign redirect_bad    = (redirect_pc_i[1:0] != 2'b00);
    assign misalign_o      = (state_reg == IF_TRAP);
`else
    assign redirect_target = word_align(redirect_pc_i);
    assign redirect_bad    = 1'b0;
`endif

    // Only REQ/HOLD consult credit; nothing is outstanding there, so occupancy alone decides.
    assign has_credit  = (fifo_count < CW'(FIFO_DEPTH));
    assign imem_req_o  = (state_reg == IF_REQ) && has_credit;
    assign imem_addr_o = pc_reg;
    assign granted     = imem_req_o && imem_gnt_i;

    assign valid_o    = !fifo_empty;
    assign instr_o    = fifo_empty ? NOP_INSTR : fifo_head.instr;
    assign pc_o       = fifo_empty ? '0 : fifo_head.pc;
    assign fifo_wdata = '{pc: pc_reg, instr: imem_rdata_i};

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        fifo_push  = 1'b0;
        fifo_pop   = valid_o && ready_i;
        fifo_flush = 1'b0;

        case (state_reg)
            IF_IDLE: state_next = IF_REQ;
            IF_REQ: begin
                if (granted) begin
                    state_next = IF_WAIT;
                end
            end
            IF_WAIT: begin
                if (imem_rvalid_i) begin
                    fifo_push = 1'b1;
                    pc_next   = pc_reg + SYS_ADDR_SPACE'(4);
                    // After this push, room remains unless the FIFO ends up full.
                    state_next = ((fifo_count < CW'(FIFO_DEPTH - 1)) || fifo_pop) ? IF_REQ : IF_HOLD;
                end
            end
            IF_HOLD: begin
                if (has_credit) begin
                    state_next = IF_REQ;
                end
            end
            IF_DRAIN: begin
                if (imem_rvalid_i) begin
                    state_next = IF_REQ;
                end
            end
            IF_TRAP: state_next = IF_TRAP;
            default: state_next = IF_IDLE;
        endcase

        if (redirect_i) begin
            fifo_flush = 1'b1;
            fifo_push  = 1'b0;
            fifo_pop   = 1'b0;
            pc_next    = redirect_target;
            case (state_reg)
                IF_WAIT:  state_next = imem_rvalid_i ? IF_REQ : IF_DRAIN;
                IF_REQ:   state_next = granted ? IF_DRAIN : IF_REQ;
                // A stale response landing with the redirect completes the drain.
                IF_DRAIN: state_next = imem_rvalid_i ? IF_REQ : IF_DRAIN;
                default:  state_next = IF_REQ;
            endcase
            if (redirect_bad) begin
                state_next = IF_TRAP;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IF_IDLE;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .srst     (rst_i),
        .flush    (fifo_flush),
        .push     (fifo_push),
        .push_data(fifo_wdata),
        .pop      (fifo_pop),
        .empty    (fifo_empty),
        .head     (fifo_head),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: memory model plus scoreboard of granted fetches, popped on ID handshakes.
// Exercises streaming, back-pressure, redirects, grant stalls, misaligned redirects and mid-fetch reset.
module tb_if_fetch;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        ready_i;
`ifdef IF_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    always #5 clk = ~clk;

    if_fetch #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i)
`ifdef IF_MISALIGN_TRAP_EN
        ,
        .misalign_o   (misalign_o)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] acc_pc[$];
    int          acc_cyc[$];

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          cyc          = 0;
    int          grant_cnt    = 0;
    int          lat          = 1;
    bit          gnt_en       = 1'b1;
    bit          resp_pend    = 1'b0;
    int          resp_wait    = 0;
    logic [31:0] resp_addr    = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] acc_at(input int i);
        return (acc_pc.size() > i) ? acc_pc[i] : 32'hDEAD_DEAD;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %h", tag, got);
        end
    endtask

    // One clock: drive memory for the coming edge, score the handshake, advance past the edge.
    task automatic cycle();
        logic [31:0] gaddr;
        imem_gnt_i    = imem_req_o && gnt_en;
        imem_rvalid_i = resp_pend && (resp_wait == 0);
        imem_rdata_i  = imem_rvalid_i ? mem_word(resp_addr) : 32'hDEAD_BEEF;
        gaddr         = imem_addr_o;
        if (rst_i || redirect_i) begin
            exp_q.delete();
        end else begin
            if (valid_o && ready_i) begin
                acc_pc.push_back(pc_o);
                acc_cyc.push_back(cyc);
                check_eq("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    check_eq("sb_pc", 64'(pc_o), 64'(exp_q[0].pc));
                    check_eq("sb_instr", 64'(instr_o), 64'(exp_q[0].instr));
                    void'(exp_q.pop_front());
                end
            end
            if (imem_req_o && imem_gnt_i) begin
                exp_q.push_back('{pc: imem_addr_o, instr: mem_word(imem_addr_o)});
            end
        end
        @(posedge clk);
        #1;
        if (imem_rvalid_i) begin
            resp_pend = 1'b0;
        end else if (resp_pend && resp_wait > 0) begin
            resp_wait--;
        end
        if (imem_gnt_i === 1'b1) begin
            resp_pend = 1'b1;
            resp_addr = gaddr;
            resp_wait = lat - 1;
            grant_cnt++;
        end
        redirect_i = 1'b0;
        cyc++;
    endtask

    task automatic wait_req(input string tag, input int max);
        int n = 0;
        while (imem_req_o !== 1'b1 && n < max) begin
            cycle();
            n++;
        end
        check_eq(tag, 64'(imem_req_o), 64'd1);
    endtask

    task automatic wait_accept(input string tag, input int mark, input int max);
        int n = 0;
        while (acc_pc.size() <= mark && n < max) begin
            cycle();
            n++;
        end
        check_eq(tag, 64'(acc_pc.size() > mark), 64'd1);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_i    = 1'b1;
        redirect_pc_i = target;
        cycle();
    endtask

    initial begin
        int mark;
        int g0;
        rst_i         = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        ready_i       = 1'b1;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;

        repeat (3) cycle();
        check_eq("rst_valid", 64'(valid_o), 64'd0);
        check_eq("rst_req", 64'(imem_req_o), 64'd0);
        check_eq("rst_addr", 64'(imem_addr_o), 64'h0);
        check_eq("rst_instr_nop", 64'(instr_o), 64'h13);
        check_eq("rst_pc", 64'(pc_o), 64'h0);
`ifdef IF_MISALIGN_TRAP_EN
        check_eq("rst_misalign", 64'(misalign_o), 64'd0);
`endif

        // Streaming: gnt immediate, rvalid one cycle later, ID always ready.
        rst_i = 1'b0;
        cyc   = 0;
        acc_pc.delete();
        acc_cyc.delete();
        repeat (12) cycle();
        check_eq("stream_pc0", 64'(acc_at(0)), 64'h0);
        check_eq("stream_pc1", 64'(acc_at(1)), 64'h4);
        check_eq("stream_pc2", 64'(acc_at(2)), 64'h8);
        check_eq("stream_first_valid_cyc", 64'(acc_cyc.size() > 0 ? acc_cyc[0] : -1), 64'd3);
        check_eq("stream_spacing", 64'(acc_cyc.size() > 2 ? acc_cyc[2] - acc_cyc[0] : -1), 64'd4);

        // Back-pressure: ID stalls for 10 cycles.
        ready_i = 1'b0;
        g0      = grant_cnt;
        repeat (3) cycle();
        check_eq("stall_valid", 64'(valid_o), 64'd1);
        repeat (7) begin
            cycle();
            check_eq("stall_head_pc", 64'(pc_o), 64'(exp_q.size() != 0 ? exp_q[0].pc : 32'hDEAD_DEAD));
            check_eq("stall_valid_hold", 64'(valid_o), 64'd1);
        end
        check_eq("stall_req_dropped", 64'(imem_req_o), 64'd0);
        check_eq("stall_grants_le_depth", 64'((grant_cnt - g0) <= DEPTH), 64'd1);
        mark    = acc_pc.size();
        ready_i = 1'b1;
        repeat (10) cycle();
        check_eq("drain_back_to_back",
                 64'(acc_cyc.size() > mark + 1 ? acc_cyc[mark+1] - acc_cyc[mark] : -1), 64'd1);

        // Redirect while WAIT; stale word returns two cycles later.
        lat = 3;
        wait_req("wait_pre_redirect_req", 10);
        cycle();
        do_redirect(32'h0000_0100);
        mark = acc_pc.size();
        wait_req("redir_wait_req", 10);
        check_eq("redir_wait_addr", 64'(imem_addr_o), 64'h100);
        wait_accept("redir_wait_accept", mark, 20);
        check_eq("redir_wait_first_pc", 64'(acc_at(mark)), 64'h100);

        // Redirect coinciding with rvalid.
        lat = 1;
        wait_req("rv_pre_redirect_req", 10);
        cycle();
        do_redirect(32'h0000_0200);
        mark = acc_pc.size();
        check_eq("redir_rv_req", 64'(imem_req_o), 64'd1);
        check_eq("redir_rv_addr", 64'(imem_addr_o), 64'h200);
        wait_accept("redir_rv_accept", mark, 20);
        check_eq("redir_rv_first_pc", 64'(acc_at(mark)), 64'h200);

        // Grant withheld: request and address hold steady.
        gnt_en = 1'b0;
        wait_req("gnt_stall_pre_req", 10);
        do_redirect(32'h0000_0300);
        mark = acc_pc.size();
        check_eq("gnt_stall_flush_valid", 64'(valid_o), 64'd0);
        repeat (5) begin
            check_eq("gnt_stall_req", 64'(imem_req_o), 64'd1);
            check_eq("gnt_stall_addr", 64'(imem_addr_o), 64'h300);
            cycle();
        end
        gnt_en = 1'b1;
        wait_accept("gnt_stall_accept", mark, 20);
        check_eq("gnt_stall_first_pc", 64'(acc_at(mark)), 64'h300);

        // Misaligned redirect.
`ifdef IF_MISALIGN_TRAP_EN
        do_redirect(32'h0000_0102);
        check_eq("trap_misalign_set", 64'(misalign_o), 64'd1);
        repeat (4) begin
            cycle();
            check_eq("trap_no_req", 64'(imem_req_o), 64'd0);
            check_eq("trap_no_valid", 64'(valid_o), 64'd0);
        end
        do_redirect(32'h0000_0104);
        mark = acc_pc.size();
        check_eq("trap_misalign_clr", 64'(misalign_o), 64'd0);
        wait_req("trap_exit_req", 10);
        check_eq("trap_exit_addr", 64'(imem_addr_o), 64'h104);
        wait_accept("trap_exit_accept", mark, 20);
        check_eq("trap_exit_first_pc", 64'(acc_at(mark)), 64'h104);
`else
        do_redirect(32'h0000_0102);
        mark = acc_pc.size();
        wait_req("misalign_req", 10);
        check_eq("misalign_forced_addr", 64'(imem_addr_o), 64'h100);
        wait_accept("misalign_accept", mark, 20);
        check_eq("misalign_first_pc", 64'(acc_at(mark)), 64'h100);
`endif

        // Reset with a response still in flight.
        lat = 3;
        wait_req("midrst_pre_req", 10);
        cycle();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        check_eq("midrst_valid", 64'(valid_o), 64'd0);
        check_eq("midrst_req", 64'(imem_req_o), 64'd0);
        check_eq("midrst_addr", 64'(imem_addr_o), 64'h0);
        mark = acc_pc.size();
        wait_accept("midrst_accept", mark, 20);
        check_eq("midrst_first_pc", 64'(acc_at(mark)), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
